// File: rtl/ordering_xfer_buf.sv
// ordering_xfer_buf: host<->node transfer buffer for one replica node's city ordering.
// Node beats are captured into a DEPTH-entry buffer and returned to the host as
// zero-padded byte-lane words. Host write beats are forwarded to the node through
// a WPIPE-stage delay line. Each burst starts with a one-cycle exchange_shift pulse.
//
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   xfer_num                 burst length minus one, latched at burst start
//   host_write/host_read     burst request and per-beat strobes
//   host_wdata               host write beat (LANES bytes)
//   host_ready               beat accepted this cycle if the matching strobe is high
//   host_rdata/host_rvalid   read beat, one cycle after acceptance
//   node_out_valid/_data     capture stream from the node
//   node_in_valid/_data      delayed write stream to the node
//   exchange_shift(_d)       burst-start pulse, and its registered copy
//   overflow/clr_overflow    sticky dropped-capture flag and its clear
module ordering_xfer_buf #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned LANE_W  = 7,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WPIPE   = 3,
  parameter int unsigned REVERSE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(DEPTH)-1:0]    xfer_num,
  input  logic                        host_write,
  input  logic                        host_read,
  input  logic [LANES*8-1:0]          host_wdata,
  output logic                        host_ready,
  output logic [LANES*8-1:0]          host_rdata,
  output logic                        host_rvalid,
  input  logic                        node_out_valid,
  input  logic [LANES*LANE_W-1:0]     node_out_data,
  output logic                        node_in_valid,
  output logic [LANES*LANE_W-1:0]     node_in_data,
  output logic                        exchange_shift,
  output logic                        exchange_shift_d,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = LANES * LANE_W;
  localparam int unsigned HW = LANES * 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] num_q;
  logic [AW:0]   wadder;
  logic [NW-1:0] mem [DEPTH];

  logic [WPIPE-1:0] pipe_v;
  logic [NW-1:0]    pipe_d [WPIPE];

  logic [NW-1:0] wr_beat;
  logic [HW-1:0] rd_word;
  logic          wr_acc;
  logic          rd_acc;
  logic          last_beat;
  logic          cap_full;
  logic          cap_wr;
  logic          cap_drop;
  logic [AW-1:0] cap_idx;
  logic          unused_wdata;

  // Host lane i pairs with node lane LANES-1-i when reversed.
  function automatic int unsigned lane_idx(input int unsigned i);
    return (REVERSE != 0) ? (LANES - 1 - i) : i;
  endfunction

  // Only the low LANE_W bits of each host byte reach the node.
  assign unused_wdata = ^host_wdata;

  // Handshake decode; gated by reset so nothing escapes while reset is held.
  assign exchange_shift = reset && (state == IDLE) && (host_write || host_read);
  assign host_ready     = reset && ((state == WRITE) ||
                                    ((state == READ) && ({1'b0, cnt} < wadder)));
  assign wr_acc         = reset && (state == WRITE) && host_write;
  assign rd_acc         = (state == READ) && host_read && host_ready;
  assign last_beat      = (cnt == num_q);

  // Capture write control: a burst start rewinds the buffer to entry 0.
  assign cap_full = (wadder == (AW+1)'(DEPTH));
  assign cap_wr   = reset && node_out_valid && (exchange_shift || !cap_full);
  assign cap_drop = reset && node_out_valid && !exchange_shift && cap_full;
  assign cap_idx  = exchange_shift ? '0 : wadder[AW-1:0];

  // Lane remapping in both directions.
  always_comb begin
    wr_beat = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_beat[lane_idx(i)*LANE_W +: LANE_W] = host_wdata[i*8 +: LANE_W];
      rd_word[i*8 +: 8] = 8'(mem[cnt][lane_idx(i)*LANE_W +: LANE_W]);
    end
  end

  // Burst control FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      num_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_write || host_read) begin
            num_q <= xfer_num;
            cnt   <= '0;
            state <= host_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_acc) begin
            cnt <= cnt + AW'(1);
            if (last_beat) state <= IDLE;
          end
        end
        READ: begin
          if (rd_acc) begin
            cnt <= cnt + AW'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture pointer and sticky overflow; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wadder   <= '0;
      overflow <= 1'b0;
    end else begin
      if (exchange_shift) wadder <= (AW+1)'(node_out_valid);
      else if (cap_wr)    wadder <= wadder + (AW+1)'(1);
      if (cap_drop)          overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (cap_wr) mem[cap_idx] <= node_out_data;
  end

  // Write delay line; stage 0 holds its data through bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_v <= '0;
      for (int unsigned k = 0; k < WPIPE; k++) pipe_d[k] <= '0;
    end else begin
      pipe_v[0] <= wr_acc;
      if (wr_acc) pipe_d[0] <= wr_beat;
      for (int unsigned k = 1; k < WPIPE; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign node_in_valid = pipe_v[WPIPE-1];
  assign node_in_data  = pipe_d[WPIPE-1];

  // Read return and delayed handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      host_rvalid      <= 1'b0;
      host_rdata       <= '0;
      exchange_shift_d <= 1'b0;
    end else begin
      host_rvalid      <= rd_acc;
      exchange_shift_d <= exchange_shift;
      if (rd_acc) host_rdata <= rd_word;
    end
  end

endmodule
